// File: rtl/race_scoreboard.sv
// race_scoreboard: records each player's position and the order they finish in, and
// drives a 4-digit display showing each player's position, or their rank once finished.
//   SCAN_DIV      clocks per display digit (2..65535)
//   clk, rst      clock, synchronous active-low reset
//   in_player     player id presented this cycle
//   in_position   position of in_player
//   in_status     status of in_player; finished = bit3 set and not 4'b1000
//   finish_count  players ranked so far (0..4)
//   finish_order  2-bit player ids; slot k holds the player that finished in place k+1
//   all_done      all four players are ranked
//   new_finish    one-cycle pulse when a rank is assigned
//   finish_player id of the most recently ranked player
//   an, seg, dp   multiplexed active-low 7-segment display; dp lit for a ranked player
module race_scoreboard #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_player,
    input  logic [2:0] in_position,
    input  logic [3:0] in_status,
    output logic [2:0] finish_count,
    output logic [7:0] finish_order,
    output logic       all_done,
    output logic       new_finish,
    output logic [1:0] finish_player,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    logic [2:0]  r_pos    [4];
    logic [2:0]  r_rank   [4];
    logic [3:0]  r_ranked;
    logic [2:0]  r_count;
    logic [7:0]  r_order;
    logic        r_new;
    logic [1:0]  r_fplayer;
    logic [15:0] r_scan;
    logic [1:0]  r_digit;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        w_fin;
    logic        w_rank;
    logic        w_wrap;
    logic [2:0]  w_val;
    logic [6:0]  w_seg;

    // 4'b1000 is a non-finishing code even though bit3 is set
    assign w_fin  = in_status[3] && (in_status != 4'b1000);
    assign w_rank = w_fin && !r_ranked[in_player] && (r_count != 3'd4);
    assign w_wrap = r_scan == 16'(SCAN_DIV - 1);
    assign w_val  = r_ranked[r_digit] ? r_rank[r_digit] : r_pos[r_digit];

    always_comb begin
        case (w_val)
            3'd0:    w_seg = 7'b1000000;
            3'd1:    w_seg = 7'b1111001;
            3'd2:    w_seg = 7'b0100100;
            3'd3:    w_seg = 7'b0110000;
            3'd4:    w_seg = 7'b0011001;
            3'd5:    w_seg = 7'b0010010;
            3'd6:    w_seg = 7'b0000010;
            default: w_seg = 7'b1111000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pos     <= '{default: '0};
            r_rank    <= '{default: '0};
            r_ranked  <= '0;
            r_count   <= '0;
            r_order   <= '0;
            r_new     <= 1'b0;
            r_fplayer <= '0;
        end else begin
            r_pos[in_player] <= in_position;
            r_new            <= w_rank;
            if (w_rank) begin
                r_ranked[in_player]                <= 1'b1;
                r_rank[in_player]                  <= r_count + 3'd1;
                r_order[{r_count[1:0], 1'b0} +: 2] <= in_player;
                r_count                            <= r_count + 3'd1;
                r_fplayer                          <= in_player;
            end
        end
    end

    // Display registers sample the table as it stood before this edge's update
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan  <= '0;
            r_digit <= '0;
            r_an    <= 4'b1111;
            r_seg   <= 7'b1111111;
            r_dp    <= 1'b1;
        end else begin
            r_scan  <= w_wrap ? 16'd0 : r_scan + 16'd1;
            r_digit <= w_wrap ? r_digit + 2'd1 : r_digit;
            r_an    <= ~(4'b0001 << r_digit);
            r_seg   <= w_seg;
            r_dp    <= ~r_ranked[r_digit];
        end
    end

    assign finish_count  = r_count;
    assign finish_order  = r_order;
    assign all_done      = r_count == 3'd4;
    assign new_finish    = r_new;
    assign finish_player = r_fplayer;
    assign an            = r_an;
    assign seg           = r_seg;
    assign dp            = r_dp;
endmodule
